bip_multilane_error_counter: RTL and testbench

- Per-lane BIP error accumulator for the 100GbE PCS receive path. It sits after alignment-marker lock and deskew.
- On each alignment-marker match per lane, it compares the received BIP against the calculated BIP and adds the number of mismatching bits to a saturating per-lane counter.
- It keeps an aggregate total and sticky overflow flags.
- It exposes a registered lane-select read port for management.

---
 rtl/bip_err_pkg.sv | 42 ++++
 rtl/bip_lane_counter.sv | 84 ++++++++
 rtl/bip_multilane_error_counter.sv | 130 +++++++++++++
 tb/tb_bip_multilane_error_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bip_err_pkg.sv
// Shared widths and helpers for the multi-lane BIP error counter.
// Optional build macro: BIP_ERR_CLEAR_ON_READ_EN (clear-on-read of the selected lane).
package bip_err_pkg;

   localparam int unsigned N_LANES_DEF    = 20;
   localparam int unsigned NB_BIP_DEF     = 8;
   localparam int unsigned NB_COUNTER_DEF = 16;
   localparam int unsigned NB_TOTAL_DEF   = 24;
   localparam int unsigned NB_SEL_DEF     = 5;

   // Common operand width for the helpers; callers zero-extend into it.
   localparam int unsigned SAT_W = 32;

   // Number of set bits in the low SAT_W bits of v.
   function automatic int unsigned popcount_bip(input logic [SAT_W-1:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < SAT_W; i++) begin
         cnt = cnt + int'(v[i]);
      end
      return cnt;
   endfunction

   // Saturating add for a width-bit counter held in SAT_W bits.
   // Bit SAT_W of the result flags that the true sum exceeded the max value.
   function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned width);
      logic [SAT_W:0] sum;
      logic [SAT_W:0] max_v;
      logic [SAT_W:0] res;
      sum   = {1'b0, a} + {1'b0, b};
      max_v = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
      if (sum > max_v) begin
         res = {1'b1, max_v[SAT_W-1:0]};
      end else begin
         res = {1'b0, sum[SAT_W-1:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/bip_lane_counter.sv
// One lane: stage-1 popcount register, saturating error counter, sticky overflow.
// Optional build macro: BIP_ERR_CLEAR_ON_READ_EN adds the i_rd_clear port.
module bip_lane_counter
   import bip_err_pkg::*;
#(
   parameter int unsigned NB_BIP     = NB_BIP_DEF,
   parameter int unsigned NB_COUNTER = NB_COUNTER_DEF,
   parameter int unsigned NB_INC     = $clog2(NB_BIP + 1)
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_am_match,
   input  logic [NB_BIP-1:0]     i_received_bip,
   input  logic [NB_BIP-1:0]     i_calculated_bip,
   input  logic                  i_clear,
`ifdef BIP_ERR_CLEAR_ON_READ_EN
   input  logic                  i_rd_clear,
`endif
   output logic [NB_INC-1:0]     o_inc,
   output logic [NB_COUNTER-1:0] o_count,
   output logic                  o_overflow
);

   logic [NB_INC-1:0]     inc_d, inc_q;
   logic [NB_COUNTER-1:0] count_d, count_q;
   logic                  ovf_d, ovf_q;
   logic [SAT_W:0]        add_res;
   logic                  unused_add_hi;

   // Stage-1 increment; a non-matching or disabled lane contributes zero.
   always_comb begin
      inc_d = '0;
      if (i_enable && i_am_match) begin
         inc_d = NB_INC'(popcount_bip(SAT_W'(i_received_bip ^ i_calculated_bip)));
      end
   end

   // Stage-1 register, flushed by reset or clear.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         inc_q <= '0;
      end else begin
         inc_q <= inc_d;
      end
   end

   // Stage-2 next state: saturating accumulate, optional clear-on-read.
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      add_res = sat_add(SAT_W'(count_q), SAT_W'(inc_q), NB_COUNTER);
`ifdef BIP_ERR_CLEAR_ON_READ_EN
      if (i_rd_clear) begin
         // Restart from zero but keep the increment landing on this edge.
         add_res = sat_add('0, SAT_W'(inc_q), NB_COUNTER);
         count_d = add_res[NB_COUNTER-1:0];
         ovf_d   = add_res[SAT_W];
      end else
`endif
      if (inc_q != '0) begin
         count_d = add_res[NB_COUNTER-1:0];
         ovf_d   = ovf_q | add_res[SAT_W];
      end
   end

   assign unused_add_hi = ^add_res[SAT_W-1:NB_COUNTER];

   // Counter and sticky flag; clear wins over any increment.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_inc      = inc_q;
   assign o_count    = count_q;
   assign o_overflow = ovf_q;

endmodule

// File: rtl/bip_multilane_error_counter.sv
// Per-lane BIP error accumulator with aggregate total and registered read port.
// Optional build macro: BIP_ERR_CLEAR_ON_READ_EN makes reads clear the selected lane.
module bip_multilane_error_counter
   import bip_err_pkg::*;
#(
   parameter int unsigned N_LANES    = N_LANES_DEF,
   parameter int unsigned NB_BIP     = NB_BIP_DEF,
   parameter int unsigned NB_COUNTER = NB_COUNTER_DEF,
   parameter int unsigned NB_TOTAL   = NB_TOTAL_DEF,
   parameter int unsigned NB_SEL     = NB_SEL_DEF
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic [N_LANES-1:0]        i_am_match,
   input  logic [N_LANES*NB_BIP-1:0] i_received_bip,
   input  logic [N_LANES*NB_BIP-1:0] i_calculated_bip,
   input  logic                      i_clear,
   input  logic                      i_rd_en,
   input  logic [NB_SEL-1:0]         i_rd_lane,
   output logic [NB_COUNTER-1:0]     o_rd_count,
   output logic                      o_rd_overflow,
   output logic                      o_rd_valid,
   output logic [NB_TOTAL-1:0]       o_total_count,
   output logic                      o_total_overflow,
   output logic [N_LANES-1:0]        o_overflow_vec
);

   localparam int unsigned NB_INC = $clog2(NB_BIP + 1);
   localparam int unsigned NB_SUM = $clog2(N_LANES * NB_BIP + 1);

   logic [NB_INC-1:0]     lane_inc   [N_LANES];
   logic [NB_COUNTER-1:0] lane_count [N_LANES];
   logic [N_LANES-1:0]    lane_ovf;

   logic [NB_SUM-1:0]     inc_sum;
   logic [SAT_W:0]        total_res;
   logic                  unused_total_hi;
   logic [NB_TOTAL-1:0]   total_q;
   logic                  total_ovf_q;

   logic [NB_COUNTER-1:0] rd_count_d, rd_count_q;
   logic                  rd_ovf_d, rd_ovf_q;
   logic                  rd_valid_q;

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
`ifdef BIP_ERR_CLEAR_ON_READ_EN
      logic rd_clear;
      assign rd_clear = i_rd_en && (i_rd_lane == NB_SEL'(k));
`endif
      bip_lane_counter #(
         .NB_BIP     (NB_BIP),
         .NB_COUNTER (NB_COUNTER),
         .NB_INC     (NB_INC)
      ) u_lane (
         .i_clock          (i_clock),
         .i_reset          (i_reset),
         .i_enable         (i_enable),
         .i_am_match       (i_am_match[k]),
         .i_received_bip   (i_received_bip[k*NB_BIP +: NB_BIP]),
         .i_calculated_bip (i_calculated_bip[k*NB_BIP +: NB_BIP]),
         .i_clear          (i_clear),
`ifdef BIP_ERR_CLEAR_ON_READ_EN
         .i_rd_clear       (rd_clear),
`endif
         .o_inc            (lane_inc[k]),
         .o_count          (lane_count[k]),
         .o_overflow       (lane_ovf[k])
      );
   end

   // Sum of all stage-1 increments feeding the total counter.
   always_comb begin
      inc_sum = '0;
      for (int k = 0; k < N_LANES; k++) begin
         inc_sum = inc_sum + NB_SUM'(lane_inc[k]);
      end
      total_res = sat_add(SAT_W'(total_q), SAT_W'(inc_sum), NB_TOTAL);
   end

   assign unused_total_hi = ^total_res[SAT_W-1:NB_TOTAL];

   // Total counter with sticky overflow, updated alongside the lane counters.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         total_q     <= '0;
         total_ovf_q <= 1'b0;
      end else begin
         total_q     <= total_res[NB_TOTAL-1:0];
         total_ovf_q <= total_ovf_q | total_res[SAT_W];
      end
   end

   // Read mux on pre-update lane state; out-of-range lanes read as zero.
   always_comb begin
      rd_count_d = rd_count_q;
      rd_ovf_d   = rd_ovf_q;
      if (i_rd_en) begin
         rd_count_d = '0;
         rd_ovf_d   = 1'b0;
         for (int k = 0; k < N_LANES; k++) begin
            if (i_rd_lane == NB_SEL'(k)) begin
               rd_count_d = lane_count[k];
               rd_ovf_d   = lane_ovf[k];
            end
         end
      end
   end

   // Read data registers hold between reads.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rd_count_q <= '0;
         rd_ovf_q   <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_count_q <= rd_count_d;
         rd_ovf_q   <= rd_ovf_d;
         rd_valid_q <= i_rd_en;
      end
   end

   assign o_rd_count       = rd_count_q;
   assign o_rd_overflow    = rd_ovf_q;
   assign o_rd_valid       = rd_valid_q;
   assign o_total_count    = total_q;
   assign o_total_overflow = total_ovf_q;
   assign o_overflow_vec   = lane_ovf;

endmodule

// File: tb/tb_bip_multilane_error_counter.sv
// Directed bench for bip_multilane_error_counter (default widths).
module tb_bip_multilane_error_counter;

   localparam int NL = 20;
   localparam int NB = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [NL-1:0]    match;
   logic [NL*NB-1:0] rx_bus;
   logic [NL*NB-1:0] calc_bus;
   logic             clr;
   logic             rd_en;
   logic [4:0]       rd_lane;
   logic [15:0]      rd_count;
   logic             rd_ovf;
   logic             rd_valid;
   logic [23:0]      total;
   logic             total_ovf;
   logic [NL-1:0]    ovf_vec;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bip_multilane_error_counter u_dut (
      .i_clock          (clk),
      .i_reset          (rst),
      .i_enable         (en),
      .i_am_match       (match),
      .i_received_bip   (rx_bus),
      .i_calculated_bip (calc_bus),
      .i_clear          (clr),
      .i_rd_en          (rd_en),
      .i_rd_lane        (rd_lane),
      .o_rd_count       (rd_count),
      .o_rd_overflow    (rd_ovf),
      .o_rd_valid       (rd_valid),
      .o_total_count    (total),
      .o_total_overflow (total_ovf),
      .o_overflow_vec   (ovf_vec)
   );

   typedef struct {
      logic          en;
      logic [NL-1:0] match;
      logic [7:0]    rx;
      logic [7:0]    calc;
      int            lane;
      int            exp_cnt;
      int            exp_total;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic set_bip(input logic [7:0] rx, input logic [7:0] calc);
      for (int k = 0; k < NL; k++) begin
         rx_bus[k*NB +: NB]   = rx;
         calc_bus[k*NB +: NB] = calc;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         match = '0;
      end
   endtask

   // One cycle of matches, then enough idle cycles for the counters to settle.
   task automatic inject(input logic e, input logic [NL-1:0] m,
                         input logic [7:0] rx, input logic [7:0] calc);
      @(negedge clk);
      en    = e;
      match = m;
      set_bip(rx, calc);
      @(negedge clk);
      match = '0;
      en    = 1'b1;
      idle(2);
   endtask

   // Issue one read strobe and sample the registered result one cycle later.
   task automatic do_read(input int lane);
      @(negedge clk);
      rd_en   = 1'b1;
      rd_lane = 5'(lane);
      @(negedge clk);
      rd_en   = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 20'h00008, 8'hA5, 8'hA4, 3, 1, 1};
      vecs[1] = '{1'b1, 20'hFFFFF, 8'hFF, 8'h00, 4, 8, 161};
      vecs[2] = '{1'b1, 20'h00000, 8'hFF, 8'h00, 7, 8, 161};
      vecs[3] = '{1'b0, 20'hFFFFF, 8'hFF, 8'h00, 8, 8, 161};
      vecs[4] = '{1'b1, 20'h00C00, 8'h0F, 8'h00, 10, 12, 169};
      vecs[5] = '{1'b1, 20'h80000, 8'h81, 8'h7E, 19, 16, 177};

      rst = 1'b1; en = 1'b1; match = '0; clr = 1'b0; rd_en = 1'b0; rd_lane = '0;
      set_bip(8'h00, 8'h00);
      repeat (3) @(negedge clk);
      check("reset_total", 32'(total), 0);
      check("reset_total_ovf", 32'(total_ovf), 0);
      check("reset_ovf_vec", 32'(ovf_vec), 0);
      check("reset_rd_count", 32'(rd_count), 0);
      check("reset_rd_valid", 32'(rd_valid), 0);
      rst = 1'b0;

      // Reset while lane 1 data sits in stage 1 drops it.
      @(negedge clk);
      match = 20'h00002;
      set_bip(8'hFF, 8'h00);
      @(negedge clk);
      match = '0;
      rst   = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(3);
      check("flush_total", 32'(total), 0);
      do_read(1);
      check("flush_lane1", 32'(rd_count), 0);

      for (int i = 0; i < 6; i++) begin
         inject(vecs[i].en, vecs[i].match, vecs[i].rx, vecs[i].calc);
         check($sformatf("vec%0d_total", i), 32'(total), 32'(vecs[i].exp_total));
         do_read(vecs[i].lane);
         check($sformatf("vec%0d_count", i), 32'(rd_count), 32'(vecs[i].exp_cnt));
         check($sformatf("vec%0d_valid", i), 32'(rd_valid), 1);
         check($sformatf("vec%0d_ovf", i), 32'(rd_ovf), 0);
      end

      // Out-of-range select reads zero, still pulses valid for one cycle.
      do_read(25);
      check("badsel_count", 32'(rd_count), 0);
      check("badsel_ovf", 32'(rd_ovf), 0);
      check("badsel_valid", 32'(rd_valid), 1);
      @(negedge clk);
      check("badsel_valid_drop", 32'(rd_valid), 0);
      check("badsel_hold", 32'(rd_count), 0);

      // Clear on the edge where lane 5 lands and lane 6 enters stage 1.
      @(negedge clk);
      match = 20'h00020;
      set_bip(8'hFF, 8'h00);
      @(negedge clk);
      match = 20'h00040;
      clr   = 1'b1;
      @(negedge clk);
      match = '0;
      clr   = 1'b0;
      check("clr_total_now", 32'(total), 0);
      idle(3);
      check("clr_total_after", 32'(total), 0);
      check("clr_ovf_vec", 32'(ovf_vec), 0);
      do_read(5);
      check("clr_lane5", 32'(rd_count), 0);
      do_read(6);
      check("clr_lane6", 32'(rd_count), 0);
      do_read(3);
      check("clr_lane3", 32'(rd_count), 0);

      // Saturation: bring lane 0 to 0xFFFC, then push past max.
      @(negedge clk);
      match = 20'h00001;
      set_bip(8'hFF, 8'h00);
      repeat (8191) @(negedge clk);
      set_bip(8'h0F, 8'h00);
      @(negedge clk);
      match = '0;
      idle(3);
      check("sat_pre_total", 32'(total), 65532);
      check("sat_pre_ovf_vec", 32'(ovf_vec), 0);
      inject(1'b1, 20'h00001, 8'hFF, 8'h00);
      check("sat_ovf_vec", 32'(ovf_vec), 1);
      check("sat_total", 32'(total), 65540);
      inject(1'b1, 20'h00001, 8'hFF, 8'h00);
      check("sat_hold_total", 32'(total), 65548);
      check("sat_total_ovf", 32'(total_ovf), 0);
      do_read(0);
      check("sat_hold_count", 32'(rd_count), 32'hFFFF);
      check("sat_rd_ovf", 32'(rd_ovf), 1);

      // Read lane 2 on the edge where a +3 increment lands.
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      idle(2);
      check("cor_cleared_ovf", 32'(ovf_vec), 0);
      inject(1'b1, 20'h00004, 8'h7F, 8'h00);
      check("cor_pre_total", 32'(total), 7);
      @(negedge clk);
      match = 20'h00004;
      set_bip(8'h07, 8'h00);
      @(negedge clk);
      match   = '0;
      rd_en   = 1'b1;
      rd_lane = 5'd2;
      @(negedge clk);
      rd_en = 1'b0;
      check("cor_rd_count", 32'(rd_count), 7);
      check("cor_rd_valid", 32'(rd_valid), 1);
      check("cor_total", 32'(total), 10);
      idle(1);
      do_read(2);
`ifdef BIP_ERR_CLEAR_ON_READ_EN
      check("cor_lane2_after", 32'(rd_count), 3);
`else
      check("cor_lane2_after", 32'(rd_count), 10);
`endif
      check("cor_total_after", 32'(total), 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
